// File: rtl/ram_sensor_poller.sv
// Periodic or on-demand sweep of NUM_CH multi-byte sensor records from the register RAM.
// Bytes fill a shadow buffer, and the complete sweep is published atomically on values.
module ram_sensor_poller #(
  parameter int CLK_HZ       = 50000000,
  parameter int POLL_HZ      = 1,
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 8,
  parameter int NUM_CH       = 2,
  parameter int BYTES_PER_CH = 2,
  parameter int BASE_ADDR    = 85,
  parameter int CH_STRIDE    = 10,
  parameter int RD_LAT       = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic                                  clk_50m,
  input  logic                                  key2,
  input  logic                                  en,
  input  logic                                  poll_now,
  output logic                                  ram_ce,
  output logic                                  ram_wre,
  output logic [ADDR_W-1:0]                     ram_address,
  input  logic [DATA_W-1:0]                     ram_do,
  output logic [NUM_CH*BYTES_PER_CH*DATA_W-1:0] values,
  output logic                                  sample_valid,
  output logic                                  busy,
  output logic                                  overrun,
  output logic [15:0]                           sample_cnt
);

  localparam int REC_W  = BYTES_PER_CH * DATA_W;
  localparam int TOT_W  = NUM_CH * REC_W;
  localparam int PERIOD = CLK_HZ / POLL_HZ;
  localparam int CNT_W  = $clog2(PERIOD);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int B_W    = (BYTES_PER_CH > 1) ? $clog2(BYTES_PER_CH) : 1;
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int SUM_W  = ADDR_W + 8;
  localparam int IDX_W  = $clog2(TOT_W);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [B_W-1:0]      b_q, b_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                capture, commit;
  logic [CNT_W-1:0]    period_cnt;
  logic                tick, req;
  logic [B_W-1:0]      slot;
  logic [IDX_W-1:0]    wr_base;
  logic [TOT_W-1:0]    shadow;

  assign tick = en && (period_cnt == CNT_W'(PERIOD - 1));
  assign req  = tick || poll_now;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50m or negedge key2) begin
    if (!key2)            period_cnt <= '0;
    else if (!en || tick) period_cnt <= '0;
    else                  period_cnt <= period_cnt + 1'b1;
  end

  always_ff @(posedge clk_50m or negedge key2) begin
    if (!key2) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      b_q     <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      b_q     <= b_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned, which would infer a latch.
    state_d = state_q;
    ch_d    = ch_q;
    b_d     = b_q;
    wait_d  = wait_q;
    capture = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_ISSUE;
          ch_d    = '0;
          b_d     = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (wait_q == WAIT_W'(RD_LAT - 1)) begin
          capture = 1'b1;
          state_d = S_ISSUE;
          if (b_q != B_W'(BYTES_PER_CH - 1)) begin
            b_d = b_q + 1'b1;
          end else begin
            b_d = '0;
            if (ch_q != CH_W'(NUM_CH - 1)) begin
              ch_d = ch_q + 1'b1;
            end else begin
              ch_d    = '0;
              state_d = S_COMMIT;
            end
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Index registers return to zero outside a sweep, so the idle address is BASE_ADDR.
  assign ram_address = ADDR_W'(SUM_W'(BASE_ADDR) + SUM_W'(ch_q) * SUM_W'(CH_STRIDE) + SUM_W'(b_q));
  assign ram_ce      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign ram_wre     = 1'b0;
  assign busy        = (state_q != S_IDLE);

  assign slot    = (MSB_FIRST != 0) ? B_W'(BYTES_PER_CH - 1) - b_q : b_q;
  assign wr_base = IDX_W'(ch_q) * IDX_W'(REC_W) + IDX_W'(slot) * IDX_W'(DATA_W);

  // NOTE: the shadow buffer is ordinary flops, not a RAM macro, so it takes the async reset too.
  always_ff @(posedge clk_50m or negedge key2) begin
    if (!key2) begin
      shadow       <= '0;
      values       <= '0;
      sample_valid <= 1'b0;
      sample_cnt   <= '0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= commit;
      if (capture) shadow[wr_base +: DATA_W] <= ram_do;
      if (commit) begin
        values     <= shadow;
        sample_cnt <= sample_cnt + 16'd1;
      end
      // A request arriving mid-sweep is dropped; only the sticky flag records it.
      if (req && busy) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_sensor_poller.sv
// Scoreboard bench: three poller configurations share a clock and reset, each with a latency-modelled RAM.
`timescale 1ns/1ps
module tb_ram_sensor_poller;

  typedef struct packed {
    logic [31:0] val;
    logic [15:0] cnt;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic [13:0] addr;
    logic [31:0] len;
  } run_t;

  logic        clk_50m = 1'b0;
  logic        key2    = 1'b0;
  int          cyc     = 0;
  int          n_cmp   = 0;
  int          n_fail  = 0;

  logic        en_w     [3];
  logic        poll_w   [3];
  logic        ce_w     [3];
  logic        wre_w    [3];
  logic [13:0] addr_w   [3];
  logic [7:0]  do_w     [3];
  logic [31:0] values_w [3];
  logic        sv_w     [3];
  logic        busy_w   [3];
  logic        ovr_w    [3];
  logic [15:0] cnt_w    [3];

  logic [7:0]  mem      [3][16384];
  logic [7:0]  pipe     [3][3];
  exp_t        sb_q     [3][$];
  run_t        log_q    [3][$];
  logic [13:0] cur_addr [3];
  int          run_len  [3];

  always #5 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc <= cyc + 1;

  // a: defaults (MSB first), b: LSB first, c: single 4-byte record with 3-cycle RAM at the top of memory
  ram_sensor_poller #(.CLK_HZ(20), .POLL_HZ(1)) dut_a (
    .clk_50m(clk_50m), .key2(key2), .en(en_w[0]), .poll_now(poll_w[0]),
    .ram_ce(ce_w[0]), .ram_wre(wre_w[0]), .ram_address(addr_w[0]), .ram_do(do_w[0]),
    .values(values_w[0]), .sample_valid(sv_w[0]), .busy(busy_w[0]), .overrun(ovr_w[0]),
    .sample_cnt(cnt_w[0]));

  ram_sensor_poller #(.CLK_HZ(20), .POLL_HZ(1), .MSB_FIRST(0)) dut_b (
    .clk_50m(clk_50m), .key2(key2), .en(en_w[1]), .poll_now(poll_w[1]),
    .ram_ce(ce_w[1]), .ram_wre(wre_w[1]), .ram_address(addr_w[1]), .ram_do(do_w[1]),
    .values(values_w[1]), .sample_valid(sv_w[1]), .busy(busy_w[1]), .overrun(ovr_w[1]),
    .sample_cnt(cnt_w[1]));

  ram_sensor_poller #(.CLK_HZ(20), .POLL_HZ(1), .NUM_CH(1), .BYTES_PER_CH(4),
                      .BASE_ADDR('h3FFE), .RD_LAT(3)) dut_c (
    .clk_50m(clk_50m), .key2(key2), .en(en_w[2]), .poll_now(poll_w[2]),
    .ram_ce(ce_w[2]), .ram_wre(wre_w[2]), .ram_address(addr_w[2]), .ram_do(do_w[2]),
    .values(values_w[2]), .sample_valid(sv_w[2]), .busy(busy_w[2]), .overrun(ovr_w[2]),
    .sample_cnt(cnt_w[2]));

  // RAM read pipelines: data for the address of cycle k is valid in cycle k+RD_LAT
  always @(posedge clk_50m) begin
    for (int d = 0; d < 3; d++) begin
      pipe[d][0] <= mem[d][addr_w[d]];
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end
  assign do_w[0] = pipe[0][0];
  assign do_w[1] = pipe[1][0];
  assign do_w[2] = pipe[2][2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: scoreboard pops on sample_valid, and address runs (address, cycles with ce high) are logged
  always @(negedge clk_50m) begin
    for (int d = 0; d < 3; d++) begin
      if (sv_w[d]) begin
        if (sb_q[d].size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sample_%0d: unexpected sample_valid at cycle %0d, required none", d, cyc);
        end else begin
          exp_t e;
          e = sb_q[d].pop_front();
          check($sformatf("values_%0d", d), values_w[d], e.val);
          check($sformatf("sample_cnt_%0d", d), cnt_w[d], e.cnt);
          check($sformatf("valid_cycle_%0d", d), cyc, e.cyc);
        end
      end
      if (ce_w[d] && run_len[d] > 0 && addr_w[d] == cur_addr[d]) begin
        run_len[d]++;
      end else begin
        if (run_len[d] > 0) log_q[d].push_back({cur_addr[d], run_len[d]});
        if (ce_w[d]) begin
          cur_addr[d] = addr_w[d];
          run_len[d]  = 1;
        end else begin
          run_len[d] = 0;
        end
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] val, input logic [15:0] cnt, input int c);
    exp_t e;
    e.val = val;
    e.cnt = cnt;
    e.cyc = c;
    sb_q[d].push_back(e);
  endtask

  task automatic check_log(input int d, input int sweeps);
    logic [13:0] pat [4];
    int          len;
    run_t        r;
    if (d == 2) begin
      pat = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
      len = 4;
    end else begin
      pat = '{14'h055, 14'h056, 14'h05F, 14'h060};
      len = 2;
    end
    check($sformatf("addr_runs_%0d", d), log_q[d].size(), sweeps * 4);
    for (int i = 0; i < sweeps * 4 && log_q[d].size() > 0; i++) begin
      r = log_q[d].pop_front();
      check($sformatf("addr_%0d_%0d", d, i), r.addr, pat[i % 4]);
      check($sformatf("addr_hold_%0d_%0d", d, i), r.len, len);
    end
    log_q[d].delete();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      en_w[d]     = 1'b0;
      poll_w[d]   = 1'b0;
      cur_addr[d] = '0;
      run_len[d]  = 0;
      for (int a = 0; a < 16384; a++) mem[d][a] = 8'h00;
    end
    for (int d = 0; d < 2; d++) begin
      mem[d][14'h055] = 8'h12;
      mem[d][14'h056] = 8'h34;
      mem[d][14'h05F] = 8'hAB;
      mem[d][14'h060] = 8'hCD;
    end
    mem[2][14'h3FFE] = 8'h11;
    mem[2][14'h3FFF] = 8'h22;
    mem[2][14'h0000] = 8'h33;
    mem[2][14'h0001] = 8'h44;

    wait_to(2);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_values_%0d", d), values_w[d], 32'h0);
      check($sformatf("rst_valid_%0d", d), sv_w[d], 1'b0);
      check($sformatf("rst_busy_%0d", d), busy_w[d], 1'b0);
      check($sformatf("rst_overrun_%0d", d), ovr_w[d], 1'b0);
      check($sformatf("rst_cnt_%0d", d), cnt_w[d], 16'h0);
      check($sformatf("rst_ce_%0d", d), ce_w[d], 1'b0);
      check($sformatf("wre_%0d", d), wre_w[d], 1'b0);
      check($sformatf("rst_addr_%0d", d), addr_w[d], (d == 2) ? 14'h3FFE : 14'h055);
    end
    key2 = 1'b1;

    // One on-demand sweep per configuration with en low
    wait_to(5);
    for (int d = 0; d < 3; d++) poll_w[d] = 1'b1;
    push_exp(0, 32'hABCD_1234, 16'd1, 15);
    push_exp(1, 32'hCDAB_3412, 16'd1, 15);
    push_exp(2, 32'h1122_3344, 16'd1, 23);
    wait_to(6);
    for (int d = 0; d < 3; d++) poll_w[d] = 1'b0;
    check("busy_rise_a", busy_w[0], 1'b1);
    check("busy_rise_c", busy_w[2], 1'b1);
    wait_to(10);
    check("ce_mid_c", ce_w[2], 1'b1);
    check("addr_mid_c", addr_w[2], 14'h3FFF);
    wait_to(14);
    check("busy_commit_a", busy_w[0], 1'b1);
    wait_to(15);
    check("busy_fall_a", busy_w[0], 1'b0);
    wait_to(40);
    for (int d = 0; d < 3; d++) check_log(d, 1);
    check("cnt_b_single", cnt_w[1], 16'd1);
    check("cnt_c_single", cnt_w[2], 16'd1);
    check("overrun_a_clear", ovr_w[0], 1'b0);

    // Automatic polling with new data: en rises at 50, ticks at 69, 89, 109, 129, 149
    mem[0][14'h055] = 8'hDE;
    mem[0][14'h056] = 8'hAD;
    mem[0][14'h05F] = 8'hBE;
    mem[0][14'h060] = 8'hEF;
    wait_to(50);
    en_w[0] = 1'b1;
    push_exp(0, 32'hBEEF_DEAD, 16'd2, 79);
    wait_to(89);
    poll_w[0] = 1'b1;
    push_exp(0, 32'hBEEF_DEAD, 16'd3, 99);
    wait_to(90);
    poll_w[0] = 1'b0;
    check("busy_coincident_a", busy_w[0], 1'b1);
    wait_to(100);
    check("overrun_coincident_a", ovr_w[0], 1'b0);
    mem[0][14'h055] = 8'h01;
    mem[0][14'h056] = 8'h02;
    mem[0][14'h05F] = 8'h03;
    mem[0][14'h060] = 8'h04;
    push_exp(0, 32'h0304_0102, 16'd4, 119);
    wait_to(112);
    poll_w[0] = 1'b1;
    wait_to(113);
    poll_w[0] = 1'b0;
    check("overrun_set_a", ovr_w[0], 1'b1);
    push_exp(0, 32'h0304_0102, 16'd5, 139);
    wait_to(140);
    check("overrun_sticky_a", ovr_w[0], 1'b1);
    wait_to(145);
    check_log(0, 4);

    // Reset after two words of the sweep started by the tick at 149
    wait_to(154);
    key2 = 1'b0;
    #1;
    check("rst_mid_ce_a", ce_w[0], 1'b0);
    check("rst_mid_busy_a", busy_w[0], 1'b0);
    check("rst_mid_values_a", values_w[0], 32'h0);
    check("rst_mid_cnt_a", cnt_w[0], 16'h0);
    check("rst_mid_overrun_a", ovr_w[0], 1'b0);
    push_exp(0, 32'h0304_0102, 16'd1, 183);
    @(negedge clk_50m);
    #1;
    key2 = 1'b1;
    for (int d = 0; d < 3; d++) log_q[d].delete();
    wait_to(160);
    check("no_commit_values_a", values_w[0], 32'h0);
    check("no_commit_cnt_a", cnt_w[0], 16'h0);
    wait_to(186);
    check_log(0, 1);
    en_w[0] = 1'b0;

    wait_to(230);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("sb_drained_%0d", d), sb_q[d].size(), 0);
      check($sformatf("no_extra_sweep_%0d", d), log_q[d].size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
